// File: rtl/imm_ext_if.sv
// ----------------------------------------------------------------------------
// imm_ext_if : decode-side and operand-side handshake bundle for imm_ext_unit
// Rev 1.0    : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface imm_ext_if #(
   parameter int IN_W  = 15,
   parameter int OUT_W = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [2:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_err;
   logic             prefix_pending;

   // Environment side: decode stage and operand-mux consumer.
   modport master (
      output flush, in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_err, prefix_pending
   );

   // Unit side.
   modport slave (
      input  flush, in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_err, prefix_pending
   );
endinterface

`default_nettype wire

// File: rtl/imm_ext_unit.sv
// ----------------------------------------------------------------------------
// imm_ext_unit : registered immediate extender (ZEXT/SEXT/UPPER/BRANCH/PREFIX)
// Rev 1.0      : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module imm_ext_unit #(
   parameter int IN_W  = 15,
   parameter int OUT_W = 32,
   parameter int SHAMT = 2
) (
   input  logic     clk,
   input  logic     reset,
   imm_ext_if.slave bus
);

   localparam logic [2:0] c_MODE_ZEXT   = 3'd0;
   localparam logic [2:0] c_MODE_SEXT   = 3'd1;
   localparam logic [2:0] c_MODE_UPPER  = 3'd2;
   localparam logic [2:0] c_MODE_BRANCH = 3'd3;
   localparam logic [2:0] c_MODE_PREFIX = 3'd4;

   localparam logic [OUT_W-1:0] c_ONES   = '1;
   localparam logic [OUT_W-1:0] c_MASK_S = c_ONES >> (OUT_W - IN_W);
   localparam logic [OUT_W-1:0] c_MASK_D = c_ONES >> (OUT_W - 2*IN_W);

   typedef enum logic [0:0] {
      S_NOPFX   = 1'b0,
      S_HAVEPFX = 1'b1
   } state_t;

   state_t           r_state;
   logic [IN_W-1:0]  r_prefix;
   logic             r_prefix_pending;
   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_err;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_have;
   logic             w_sign;
   logic [OUT_W-1:0] w_mask;
   logic [OUT_W-1:0] w_zext;
   logic [OUT_W-1:0] w_sext;
   logic [OUT_W-1:0] w_upper;
   logic [OUT_W-1:0] w_branch;
   logic [OUT_W-1:0] w_next_data;
   logic             w_next_err;

   assign w_in_ready = !bus.flush && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_have     = (r_state == S_HAVEPFX);

   // Effective operand is {prefix, imm} when a prefix is held, else imm alone.
   always_comb begin
      w_zext = OUT_W'(bus.in_imm);
      w_sign = bus.in_imm[IN_W-1];
      w_mask = c_MASK_S;
      if (w_have) begin
         w_zext = (OUT_W'(r_prefix) << IN_W) | OUT_W'(bus.in_imm);
         w_sign = r_prefix[IN_W-1];
         w_mask = c_MASK_D;
      end
      w_sext   = w_sign ? (w_zext | ~w_mask) : w_zext;
      w_upper  = OUT_W'(bus.in_imm) << (OUT_W - IN_W);
      w_branch = w_sext << SHAMT;
   end

   always_comb begin
      w_next_data = '0;
      w_next_err  = 1'b0;
      case (bus.in_mode)
         c_MODE_ZEXT:   w_next_data = w_zext;
         c_MODE_SEXT:   w_next_data = w_sext;
         c_MODE_UPPER:  w_next_data = w_upper;
         c_MODE_BRANCH: w_next_data = w_branch;
         c_MODE_PREFIX: w_next_data = '0;
         default:       w_next_err  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= S_NOPFX;
         r_prefix         <= '0;
         r_prefix_pending <= 1'b0;
         r_out_valid      <= 1'b0;
         r_out_data       <= '0;
         r_out_err        <= 1'b0;
      end else if (bus.flush) begin
         r_state          <= S_NOPFX;
         r_prefix_pending <= 1'b0;
         r_out_valid      <= 1'b0;
      end else begin
         // Drain first; a same-cycle load below overrides it with no bubble.
         if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (bus.in_mode == c_MODE_PREFIX) begin
               r_state          <= S_HAVEPFX;
               r_prefix         <= bus.in_imm;
               r_prefix_pending <= 1'b1;
            end else begin
               r_state          <= S_NOPFX;
               r_prefix_pending <= 1'b0;
               r_out_valid      <= 1'b1;
               r_out_data       <= w_next_data;
               r_out_err        <= w_next_err;
            end
         end
      end
   end

   assign bus.in_ready       = w_in_ready;
   assign bus.out_valid      = r_out_valid;
   assign bus.out_data       = r_out_data;
   assign bus.out_err        = r_out_err;
   assign bus.prefix_pending = r_prefix_pending;

endmodule

`default_nettype wire
